// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the RV32I front end.
// Holds the IF/ID entry layout and the values the buffer drives when empty.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_entry_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    localparam logic [31:0] IF_ID_PC_RESET    = 32'h0000_0000;
    localparam logic [31:0] IF_ID_INSTR_RESET = RV_NOP;

endpackage

// File: rtl/if_id_buffer.sv
// In-order queue between fetch and decode: back-pressures fetch when full,
// presents the oldest {pc, instr} to decode and drops everything on a redirect.
module if_id_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter logic [31:0] NOP   = RV_NOP
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_instr,
    input  logic                     i_valid,
    output logic                     o_if_ready,
    input  logic                     i_flush,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_instr,
    output logic                     o_valid,
    input  logic                     i_id_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if_id_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            push;
    logic            pop;

    // Ready and valid come from the registered count only, so there is no
    // combinational path from decode's ready back into fetch.
    assign o_valid    = (count_q != '0);
    assign o_if_ready = (count_q != FULL);
    assign o_count    = count_q;

    assign push = i_valid && o_if_ready && !i_flush;
    assign pop  = o_valid && i_id_ready && !i_flush;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage is not reset or cleared on flush; the count alone marks validity.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= '{pc: i_pc, instr: i_instr};
    end

    always_comb begin
        o_pc    = IF_ID_PC_RESET;
        o_instr = NOP;
        if (o_valid) begin
            o_pc    = mem_q[rd_ptr_q].pc;
            o_instr = mem_q[rd_ptr_q].instr;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_id_buffer;
    import pipe_pkg::*;

    localparam int DEPTH = 2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_instr = '0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_id_ready = 1'b0;
    logic        o_if_ready;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_valid;
    logic [$clog2(DEPTH):0] o_count;

    int checks = 0;
    int errors = 0;

    if_id_entry_t mq[$];

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_pc       (i_pc),
        .i_instr    (i_instr),
        .i_valid    (i_valid),
        .o_if_ready (o_if_ready),
        .i_flush    (i_flush),
        .o_pc       (o_pc),
        .o_instr    (o_instr),
        .o_valid    (o_valid),
        .i_id_ready (i_id_ready),
        .o_count    (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue limited to DEPTH by the ready rule.
    always @(posedge i_clk) begin
        if (i_reset) begin
            bit can_push, can_pop;
            can_push = i_valid && (mq.size() != DEPTH) && !i_flush;
            can_pop  = (mq.size() != 0) && i_id_ready && !i_flush;
            if (i_flush) mq.delete();
            else begin
                if (can_pop)  void'(mq.pop_front());
                if (can_push) mq.push_back('{pc: i_pc, instr: i_instr});
            end
        end
    end

    always @(negedge i_reset) mq.delete();

    // Outputs are registered, so mid-cycle sampling sees a settled state.
    always @(negedge i_clk) begin
        int n;
        n = mq.size();
        chk("m_valid", 32'(o_valid), 32'(n != 0));
        chk("m_ready", 32'(o_if_ready), 32'(n != DEPTH));
        chk("m_count", 32'(o_count), 32'(n));
        if (n != 0) begin
            chk("m_pc", o_pc, mq[0].pc);
            chk("m_instr", o_instr, mq[0].instr);
        end else begin
            chk("m_pc_empty", o_pc, 32'h0);
            chk("m_instr_empty", o_instr, 32'h13);
        end
    end

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'h0050_0093;
    endfunction

    // Hold inputs for one cycle; return 1 time unit after the edge.
    task automatic drive(input bit v, input logic [31:0] pc, input bit r, input bit f);
        i_valid    = v;
        i_pc       = pc;
        i_instr    = ins(pc);
        i_id_ready = r;
        i_flush    = f;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge i_clk);
        #1;
        chk("por_valid", 32'(o_valid), 32'h0);
        chk("por_instr", o_instr, 32'h13);
        chk("por_ready", 32'(o_if_ready), 32'h1);
        #2 i_reset = 1'b1;

        // Streaming: each pair is presented exactly one cycle after its push
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            chk("stream_pc", o_pc, 32'(i * 4));
            chk("stream_ready", 32'(o_if_ready), 32'h1);
            chk("stream_count", 32'(o_count), 32'h1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_valid", 32'(o_valid), 32'h0);

        // Stall fill
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        chk("fill1_pc", o_pc, 32'h100);
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        chk("full_count", 32'(o_count), 32'h2);
        chk("full_ready", 32'(o_if_ready), 32'h0);
        chk("full_pc", o_pc, 32'h100);
        // Full: pop proceeds, push of 0x108 refused
        drive(1'b1, 32'h108, 1'b1, 1'b0);
        chk("popfull_count", 32'(o_count), 32'h1);
        chk("popfull_pc", o_pc, 32'h104);
        chk("popfull_ready", 32'(o_if_ready), 32'h1);
        drive(1'b1, 32'h108, 1'b1, 1'b0);
        chk("retry_pc", o_pc, 32'h108);
        chk("retry_count", 32'(o_count), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain2_count", 32'(o_count), 32'h0);

        // Asynchronous reset mid-stream with two entries held
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        chk("prerst_count", 32'(o_count), 32'h2);
        i_valid = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_instr", o_instr, 32'h13);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_ready", 32'(o_if_ready), 32'h1);
        chk("rst_count", 32'(o_count), 32'h0);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("postrst_valid", 32'(o_valid), 32'h0);

        // Flush discards held entries and the pair fetched in the flush cycle
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        drive(1'b1, 32'h208, 1'b0, 1'b1);
        chk("flush_valid", 32'(o_valid), 32'h0);
        chk("flush_count", 32'(o_count), 32'h0);
        chk("flush_ready", 32'(o_if_ready), 32'h1);
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        chk("redirect_pc", o_pc, 32'h400);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("redirect_drain", 32'(o_valid), 32'h0);

        // Random traffic across many pointer wraps, with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("final_count", 32'(o_count), 32'h0);

        @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
